// File: rtl/laser_link_receiver_pkg.sv
// laser_pkg: shared types and constants for the dual-lane laser link receiver.
//   lane_state_t    : per-lane deframer state
//   FRAME_DATA_BITS : data bits carried by one line frame
//   LAST_BIT_IDX    : bit index of the final data bit in a frame
package laser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } lane_state_t;

    localparam int FRAME_DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT_IDX = 3'(FRAME_DATA_BITS - 1);

endpackage

// File: rtl/laser_link_receiver_deframer.sv
// laser_lane_deframer: one receive lane of the laser link.
// Synchronises the photodiode input, finds the start bit, samples each bit
// mid-window and reports one byte per frame.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   en         in   receive enable; low forces the lane idle
//   line_in    in   raw photodiode input, asynchronous to clock
//   byte_done  out  1-cycle pulse: frame ended with a valid (low) stop bit
//   frame_err  out  1-cycle pulse: stop bit sampled high, byte dropped
//   data_out   out  received byte, valid while byte_done is high
module laser_lane_deframer
    import laser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       line_in,
    output logic                       byte_done,
    output logic                       frame_err,
    output logic [FRAME_DATA_BITS-1:0] data_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    // [0],[1]: 2-FF synchroniser; [2]: previous synchronised value for edge detection
    logic [2:0]                 sync_q;
    logic                       line_s;
    logic                       line_rise;

    lane_state_t                state;
    logic [CW-1:0]              bit_cnt;
    logic [2:0]                 bit_idx;
    logic [FRAME_DATA_BITS-1:0] shift_q;

    assign line_s    = sync_q[1];
    assign line_rise = sync_q[1] & ~sync_q[2];
    assign data_out  = shift_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], line_in};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                bit_cnt <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (line_rise) begin
                            bit_cnt <= HALF_BIT;
                            state   <= START;
                        end
                    end
                    START: begin
                        if (bit_cnt == '0) begin
                            // Start bit must still be high mid-window, else treat as a glitch.
                            if (line_s) begin
                                bit_cnt <= FULL_BIT;
                                bit_idx <= '0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == '0) begin
                            shift_q <= {line_s, shift_q[FRAME_DATA_BITS-1:1]};
                            bit_cnt <= FULL_BIT;
                            if (bit_idx == LAST_BIT_IDX) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_cnt == '0) begin
                            if (line_s) begin
                                frame_err <= 1'b1;
                            end else begin
                                byte_done <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/laser_link_receiver.sv
// laser_link_receiver: dual-lane optical receive front end.
// Deframes one byte per lane and pairs the two lane bytes into one output word.
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   en           in   receive enable; low idles lanes and discards pending bytes
//   laser1_in    in   lane 1 photodiode (asynchronous)
//   laser2_in    in   lane 2 photodiode (asynchronous)
//   data1_out    out  lane 1 byte of last valid pair
//   data2_out    out  lane 2 byte of last valid pair
//   data_valid   out  1-cycle pulse: new pair presented
//   frame_err    out  per-lane pulse: stop bit high
//   overrun      out  per-lane pulse: unpaired pending byte overwritten
//   timeout_err  out  pulse: lone pending byte dropped after PAIR_TIMEOUT
//   err_count    out  saturating count of cycles with any error pulse
module laser_link_receiver
    import laser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PAIR_TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       laser1_in,
    input  logic                       laser2_in,
    output logic [FRAME_DATA_BITS-1:0] data1_out,
    output logic [FRAME_DATA_BITS-1:0] data2_out,
    output logic                       data_valid,
    output logic [1:0]                 frame_err,
    output logic [1:0]                 overrun,
    output logic                       timeout_err,
    output logic [7:0]                 err_count
);

    localparam int TW = $clog2(PAIR_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(PAIR_TIMEOUT - 1);

    logic [1:0]                 lane_done;
    logic [1:0]                 lane_ferr;
    logic [FRAME_DATA_BITS-1:0] lane1_byte;
    logic [FRAME_DATA_BITS-1:0] lane2_byte;

    logic [1:0]                 pend_q;
    logic [FRAME_DATA_BITS-1:0] pend1_q;
    logic [FRAME_DATA_BITS-1:0] pend2_q;
    logic [TW-1:0]              tmo_cnt;

    logic [1:0]                 have;
    logic [FRAME_DATA_BITS-1:0] next1;
    logic [FRAME_DATA_BITS-1:0] next2;
    logic [1:0]                 ovr_now;
    logic                       pair_now;
    logic                       lone_now;
    logic                       tmo_now;
    logic                       err_any;

    laser_lane_deframer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_lane1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .line_in   (laser1_in),
        .byte_done (lane_done[0]),
        .frame_err (lane_ferr[0]),
        .data_out  (lane1_byte)
    );

    laser_lane_deframer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_lane2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .line_in   (laser2_in),
        .byte_done (lane_done[1]),
        .frame_err (lane_ferr[1]),
        .data_out  (lane2_byte)
    );

    // A byte finishing this cycle counts as present, so a same-cycle pair
    // is delivered on the very next edge.
    always_comb begin
        have     = pend_q | lane_done;
        next1    = lane_done[0] ? lane1_byte : pend1_q;
        next2    = lane_done[1] ? lane2_byte : pend2_q;
        ovr_now  = pend_q & lane_done;
        pair_now = &have;
        lone_now = ^have;
        tmo_now  = lone_now && (tmo_cnt == TMO_LAST);
        err_any  = (|lane_ferr) || (|ovr_now) || tmo_now;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            pend1_q     <= '0;
            pend2_q     <= '0;
            tmo_cnt     <= '0;
            data1_out   <= '0;
            data2_out   <= '0;
            data_valid  <= 1'b0;
            frame_err   <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
            err_count   <= '0;
        end else begin
            data_valid  <= 1'b0;
            frame_err   <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
            if (!en) begin
                pend_q  <= '0;
                tmo_cnt <= '0;
            end else begin
                frame_err   <= lane_ferr;
                overrun     <= ovr_now;
                timeout_err <= tmo_now;
                if (lane_done[0]) pend1_q <= lane1_byte;
                if (lane_done[1]) pend2_q <= lane2_byte;
                if (pair_now) begin
                    data1_out  <= next1;
                    data2_out  <= next2;
                    data_valid <= 1'b1;
                    pend_q     <= '0;
                    tmo_cnt    <= '0;
                end else if (tmo_now) begin
                    pend_q  <= '0;
                    tmo_cnt <= '0;
                end else if (lone_now) begin
                    pend_q  <= have;
                    tmo_cnt <= tmo_cnt + 1'b1;
                end else begin
                    pend_q  <= '0;
                    tmo_cnt <= '0;
                end
                if (err_any && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
